fetch_decode: RTL
=================

FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have parameter RESET_PC, default 19'd0, the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port imem_req  output  1  instruction fetch request; imem_addr  output  19  fetch address (equals pc).
REQ-005 SHALL have port imem_ack  input  1  fetch complete; imem_data  input  19  instruction word, valid when imem_ack=1.
REQ-006 SHALL have port alu_valid  output  1  issue valid; alu_ready  input  1  ALU accepts issue.
REQ-007 SHALL have ports alu_mode  output  5  opcode; alu_r1, alu_r2, alu_r3, alu_addr  output  19 each  operand buses to the ALU.
REQ-008 SHALL have ports wb_valid  input  1, wb_data  input  19  ALU result return.
REQ-009 SHALL have ports redirect_valid  input  1, redirect_pc  input  19  ALU PC update for JMP/CALL/RET.
REQ-010 SHALL have ports pc  output  19, illegal  output  1 (sticky), instr_count  output  16  retired instructions.

Function
REQ-011 Instruction format SHALL be: [18:14] opcode, [13:11] rd, [10:8] rs1, [7:5] rs2, [10:0] addr11.
REQ-012 Register file SHALL be 8 x 19-bit, all writable, all zero at reset.
REQ-013 FSM states SHALL be FETCH, DECODE, ISSUE, WAIT, HALT.
REQ-014 FETCH: imem_req=1 and imem_addr=pc until the cycle with imem_ack=1; the word is latched that cycle; next state DECODE.
REQ-015 DECODE (one cycle): opcode>16 -> illegal=1, next HALT; otherwise operands latched, next ISSUE.
REQ-016 Operands: alu_mode=opcode, alu_r1=reg[rd], alu_r2=reg[rs1], alu_r3=reg[rs2], alu_addr=zero-extended addr11, except opcodes 10-16 SHALL drive alu_r2=reg[rd] and alu_r3=0.
REQ-017 ISSUE: alu_valid=1 with all alu_* buses held stable until alu_valid and alu_ready are both 1 in the same cycle; next WAIT.
REQ-018 WAIT, opcodes 0-9 and 15: hold until wb_valid=1, then reg[rd]<=wb_data and pc<=pc+1.
REQ-019 WAIT, opcodes 11/12: hold until wb_valid=1, then pc<=wb_data if wb_data!=0, else pc+1; no register write.
REQ-020 WAIT, opcodes 10/13/14: hold until redirect_valid=1, then pc<=redirect_pc.
REQ-021 WAIT, opcode 16 (ST): SHALL last exactly one cycle, then pc<=pc+1.
REQ-022 Each WAIT exit SHALL increment instr_count by 1 (wraps 16'hFFFF -> 0) and transition to FETCH.
REQ-023 wb_valid/redirect_valid outside WAIT, or not matching the current opcode class, SHALL be ignored.
REQ-024 If both wb_valid and redirect_valid are asserted in WAIT, only the input matching the opcode class SHALL be used.
REQ-025 pc+1 SHALL wrap from 19'h7FFFF to 0.
REQ-026 HALT SHALL be terminal until rst: imem_req=0, alu_valid=0, illegal=1.
REQ-027 The alu_* buses SHALL be don't-care while alu_valid=0; alu_valid and imem_req SHALL never both be 1.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL set state=FETCH, pc=RESET_PC, regs=0, illegal=0, instr_count=0; imem_req=0, alu_valid=0 during the reset cycle.
REQ-029 Reset asserted in any state, including mid-handshake, SHALL abort the operation without any register write; imem_req SHALL assert in the first cycle after rst drops.

Verification
REQ-030 ADD: reg1=5, reg2=7, instr {0,rd=3,rs1=1,rs2=2}, ALU returns wb_data=12 -> reg3=12, pc=1, instr_count=1.
REQ-031 Issue stall: alu_ready held low 4 cycles -> alu_valid and buses stay constant for 5 cycles; exactly one issue occurs.
REQ-032 BEQ: wb_data=19'd40 -> pc=40; wb_data=0 -> pc=pc+1.
REQ-033 CALL (13) with redirect_pc=100 and a simultaneous spurious wb_valid -> pc=100, no register write.
REQ-034 Illegal: opcode 17 -> illegal=1, HALT, no further imem_req; rst then clears illegal and fetches from RESET_PC.
REQ-035 Edges: pc=19'h7FFFF executing INC -> pc=0; rst asserted during WAIT with wb_valid=1 -> rd unchanged (0), pc=RESET_PC.

Source files
------------

// File: rtl/fetch_decode_if.sv
// Handshake bundle between fetch_decode and its instruction memory, ALU and
// writeback/redirect return paths.
interface fetch_decode_if;
    logic        imem_req;
    logic [18:0] imem_addr;
    logic        imem_ack;
    logic [18:0] imem_data;

    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_mode;
    logic [18:0] alu_r1;
    logic [18:0] alu_r2;
    logic [18:0] alu_r3;
    logic [18:0] alu_addr;

    logic        wb_valid;
    logic [18:0] wb_data;
    logic        redirect_valid;
    logic [18:0] redirect_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        output alu_valid, alu_mode, alu_r1, alu_r2, alu_r3, alu_addr,
        input  alu_ready,
        input  wb_valid, wb_data, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        input  alu_valid, alu_mode, alu_r1, alu_r2, alu_r3, alu_addr,
        output alu_ready,
        output wb_valid, wb_data, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_decode.sv
// Single-issue fetch/decode front end: fetches a word, reads the register
// file, hands operands to an external ALU and retires on writeback/redirect.
module fetch_decode #(
    parameter logic [18:0] RESET_PC = 19'd0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_decode_if.master bus,
    output logic [18:0]   pc,
    output logic          illegal,
    output logic [15:0]   instr_count
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        ISSUE,
        WAIT,
        HALT
    } state_t;

    state_t      state_q, state_d;
    logic [18:0] pc_q, pc_d;
    logic [18:0] instr_q, instr_d;
    logic        illegal_q, illegal_d;
    logic [15:0] count_q, count_d;
    logic [4:0]  mode_q, mode_d;
    logic [18:0] r1_q, r1_d;
    logic [18:0] r2_q, r2_d;
    logic [18:0] r3_q, r3_d;
    logic [18:0] addr_q, addr_d;
    logic [18:0] regs_q [8];

    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [18:0] rf_wdata;
    logic        retire;

    logic [4:0]  opc;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [18:0] pc_inc;
    logic        is_wb_op;
    logic        is_branch;
    logic        is_jump;

    assign opc    = instr_q[18:14];
    assign rd     = instr_q[13:11];
    assign rs1    = instr_q[10:8];
    assign rs2    = instr_q[7:5];
    assign pc_inc = pc_q + 19'd1;

    // Retire class is taken from the latched opcode, so it stays fixed through WAIT.
    assign is_wb_op  = (mode_q <= 5'd9) || (mode_q == 5'd15);
    assign is_branch = (mode_q == 5'd11) || (mode_q == 5'd12);
    assign is_jump   = (mode_q == 5'd10) || (mode_q == 5'd13) || (mode_q == 5'd14);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        illegal_d = illegal_q;
        count_d   = count_q;
        mode_d    = mode_q;
        r1_d      = r1_q;
        r2_d      = r2_q;
        r3_d      = r3_q;
        addr_d    = addr_q;
        rf_we     = 1'b0;
        rf_waddr  = rd;
        rf_wdata  = bus.wb_data;
        retire    = 1'b0;

        case (state_q)
            FETCH: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_data;
                    state_d = DECODE;
                end
            end

            DECODE: begin
                if (opc > 5'd16) begin
                    illegal_d = 1'b1;
                    state_d   = HALT;
                end else begin
                    mode_d = opc;
                    r1_d   = regs_q[rd];
                    addr_d = {8'd0, instr_q[10:0]};
                    // Control-flow and opcode 15 compare against rd rather than rs1/rs2.
                    if (opc >= 5'd10) begin
                        r2_d = regs_q[rd];
                        r3_d = 19'd0;
                    end else begin
                        r2_d = regs_q[rs1];
                        r3_d = regs_q[rs2];
                    end
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (bus.alu_ready) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (is_wb_op) begin
                    if (bus.wb_valid) begin
                        rf_we  = 1'b1;
                        pc_d   = pc_inc;
                        retire = 1'b1;
                    end
                end else if (is_branch) begin
                    if (bus.wb_valid) begin
                        pc_d   = (bus.wb_data != 19'd0) ? bus.wb_data : pc_inc;
                        retire = 1'b1;
                    end
                end else if (is_jump) begin
                    if (bus.redirect_valid) begin
                        pc_d   = bus.redirect_pc;
                        retire = 1'b1;
                    end
                end else begin
                    pc_d   = pc_inc;
                    retire = 1'b1;
                end

                if (retire) begin
                    count_d = count_q + 16'd1;
                    state_d = FETCH;
                end
            end

            HALT: begin
                illegal_d = 1'b1;
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= 19'd0;
            illegal_q <= 1'b0;
            count_q   <= 16'd0;
            mode_q    <= 5'd0;
            r1_q      <= 19'd0;
            r2_q      <= 19'd0;
            r3_q      <= 19'd0;
            addr_q    <= 19'd0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 19'd0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
            mode_q    <= mode_d;
            r1_q      <= r1_d;
            r2_q      <= r2_d;
            r3_q      <= r3_d;
            addr_q    <= addr_d;
            if (rf_we) begin
                regs_q[rf_waddr] <= rf_wdata;
            end
        end
    end

    // Requests are masked while rst is high so nothing leaks out in the reset cycle.
    assign bus.imem_req  = (state_q == FETCH) && !rst;
    assign bus.imem_addr = pc_q;
    assign bus.alu_valid = (state_q == ISSUE) && !rst;
    assign bus.alu_mode  = mode_q;
    assign bus.alu_r1    = r1_q;
    assign bus.alu_r2    = r2_q;
    assign bus.alu_r3    = r3_q;
    assign bus.alu_addr  = addr_q;

    assign pc          = pc_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule
